// File: rtl/cmd_seq_pkg.sv
// Shared definitions for the command sequencer: opcodes, FSM states and
// field positions inside the {command, number, address} instruction word.
package cmd_seq_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_STI  = 4'h2;
  localparam logic [3:0] OP_LD   = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_STR  = 4'h5;
  localparam logic [3:0] OP_BZ   = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    HOLD  = 3'd2,
    HALT  = 3'd3,
    PAUSE = 3'd4
  } state_t;

  // Field index inside the word; bit offset is index * DATA_W
  localparam int CMD_FIELD  = 2;
  localparam int NUM_FIELD  = 1;
  localparam int ADDR_FIELD = 0;

endpackage

// File: rtl/cmd_prog_mem.sv
// Program store: DEPTH x WORD_W register file, one synchronous write port
// and one combinational read port. Contents survive reset.
module cmd_prog_mem #(
  parameter int WORD_W = 48,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cmd_sequencer.sv
// Streams {command, number, address} words to the CPU, adding HALT and
// branch-if-zero. Define SEQ_STEP_EN to add single-step (step port, PAUSE).
//
// state | meaning
// IDLE  | waiting for start, outputs 0, program writable
// RUN   | decode mem[pc] each edge and issue / branch / halt
// HOLD  | keep an ALU instruction on the outputs one extra cycle
// HALT  | stopped (done=1), program writable, start restarts
// PAUSE | single-step only: hold outputs and pc until step
module cmd_sequencer
  import cmd_seq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                prog_we,
  input  logic [AW-1:0]       prog_addr,
  input  logic [3*DATA_W-1:0] prog_wdata,
  input  logic                start,
  input  logic                zo_in,
  output logic [DATA_W-1:0]   cmd_out,
  output logic [DATA_W-1:0]   num_out,
  output logic [DATA_W-1:0]   addr_out,
  output logic [AW-1:0]       pc,
  output logic                busy,
  output logic                done,
  output logic                err
`ifdef SEQ_STEP_EN
  ,input  logic               step
`endif
);

`ifdef SEQ_STEP_EN
  localparam state_t ISSUE_NEXT = PAUSE;
`else
  localparam state_t ISSUE_NEXT = RUN;
`endif

  state_t              state_q, state_d;
  logic [AW-1:0]       pc_d;
  logic [DATA_W-1:0]   cmd_d, num_d, addr_d;
  logic                busy_d, done_d, err_d;
  logic                end_q, end_d;
  logic [3*DATA_W-1:0] instr;
  logic [DATA_W-1:0]   i_cmd, i_num, i_addr;
  logic [3:0]          op;
  logic                at_last;
  logic                mem_we;

  assign mem_we = prog_we && (state_q == IDLE || state_q == HALT);

  cmd_prog_mem #(
    .WORD_W(3*DATA_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(prog_addr),
    .wdata(prog_wdata),
    .raddr(pc),
    .rdata(instr)
  );

  assign i_cmd   = instr[CMD_FIELD*DATA_W  +: DATA_W];
  assign i_num   = instr[NUM_FIELD*DATA_W  +: DATA_W];
  assign i_addr  = instr[ADDR_FIELD*DATA_W +: DATA_W];
  assign op      = i_cmd[DATA_W-1 -: 4];
  assign at_last = (pc == AW'(DEPTH-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc       <= '0;
      cmd_out  <= '0;
      num_out  <= '0;
      addr_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      end_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc       <= pc_d;
      cmd_out  <= cmd_d;
      num_out  <= num_d;
      addr_out <= addr_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
      end_q    <= end_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc;
    cmd_d   = cmd_out;
    num_d   = num_out;
    addr_d  = addr_out;
    err_d   = err;
    end_d   = end_q;

    case (state_q)
      IDLE: begin
        cmd_d  = '0;
        num_d  = '0;
        addr_d = '0;
        if (start) begin
          pc_d    = '0;
          end_d   = 1'b0;
          state_d = RUN;
        end
      end

      RUN: begin
        // end_q marks that the last entry was already consumed without a HALT
        if (end_q) begin
          cmd_d   = '0;
          num_d   = '0;
          addr_d  = '0;
          err_d   = 1'b1;
          state_d = HALT;
        end else begin
          case (op)
            OP_HALT: begin
              cmd_d   = '0;
              num_d   = '0;
              addr_d  = '0;
              state_d = HALT;
            end
            OP_BZ: begin
              cmd_d  = '0;
              num_d  = '0;
              addr_d = '0;
              if (zo_in)        pc_d  = i_addr[AW-1:0];
              else if (at_last) end_d = 1'b1;
              else              pc_d  = pc + AW'(1);
            end
            default: begin
              cmd_d  = i_cmd;
              num_d  = i_num;
              addr_d = i_addr;
              if (at_last) end_d = 1'b1;
              else         pc_d  = pc + AW'(1);
              state_d = (op == OP_ADD) ? HOLD : ISSUE_NEXT;
            end
          endcase
        end
      end

      HOLD: state_d = ISSUE_NEXT;

      HALT: begin
        cmd_d  = '0;
        num_d  = '0;
        addr_d = '0;
        if (start) begin
          pc_d    = '0;
          err_d   = 1'b0;
          end_d   = 1'b0;
          state_d = RUN;
        end
      end

      PAUSE: begin
`ifdef SEQ_STEP_EN
        if (step) state_d = RUN;
`else
        state_d = IDLE;
`endif
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN) || (state_d == HOLD) || (state_d == PAUSE);
    done_d = (state_d == HALT);
  end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed self-checking bench for cmd_sequencer: straight-line program
// execution, branch-if-zero, run-off-end, write/start lockout and async reset.
module tb_cmd_sequencer;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                prog_we = 1'b0;
  logic [AW-1:0]       prog_addr = '0;
  logic [3*DATA_W-1:0] prog_wdata = '0;
  logic                start = 1'b0;
  logic                zo_in = 1'b0;
  logic [DATA_W-1:0]   cmd_out, num_out, addr_out;
  logic [AW-1:0]       pc;
  logic                busy, done, err;
`ifdef SEQ_STEP_EN
  logic                step = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  cmd_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_wdata(prog_wdata),
    .start     (start),
    .zo_in     (zo_in),
    .cmd_out   (cmd_out),
    .num_out   (num_out),
    .addr_out  (addr_out),
    .pc        (pc),
    .busy      (busy),
    .done      (done),
    .err       (err)
`ifdef SEQ_STEP_EN
    ,.step     (step)
`endif
  );

  always #5 clk = ~clk;

  logic [15:0] s1_cmd [7] = '{16'h2000, 16'h2000, 16'h3000, 16'h3001, 16'h4000, 16'h4000, 16'h5000};
  logic [15:0] s1_num [7] = '{16'h0008, 16'h0004, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
  logic [15:0] s1_adr [7] = '{16'h0000, 16'h0001, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0002};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [3:0] a, input logic [15:0] c, input logic [15:0] n, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = a; prog_wdata = {c, n, d};
    @(posedge clk); #1;
    prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_out(input string tag, input logic [15:0] c, input logic [15:0] n, input logic [15:0] d);
    chk({tag, ".cmd"}, cmd_out, c);
    chk({tag, ".num"}, num_out, n);
    chk({tag, ".addr"}, addr_out, d);
  endtask

  task automatic load_s1();
    load(4'd0, 16'h2000, 16'h0008, 16'h0000);
    load(4'd1, 16'h2000, 16'h0004, 16'h0001);
    load(4'd2, 16'h3000, 16'h0000, 16'h0000);
    load(4'd3, 16'h3001, 16'h0000, 16'h0001);
    load(4'd4, 16'h4000, 16'h0000, 16'h0000);
    load(4'd5, 16'h5000, 16'h0000, 16'h0002);
    load(4'd6, 16'hF000, 16'h0000, 16'h0000);
  endtask

  initial begin
    // reset state
    #12;
    chk_out("reset", 16'h0, 16'h0, 16'h0);
    chk("reset.pc", pc, 0);
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    chk("reset.err", err, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // straight-line program with one ALU hold
    load_s1();
    pulse_start();
    chk("s1.busy_after_start", busy, 1);
    chk("s1.cmd_after_start", cmd_out, 0);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk_out($sformatf("s1.issue%0d", i), s1_cmd[i], s1_num[i], s1_adr[i]);
    end
    tick();
    chk_out("s1.halt", 16'h0, 16'h0, 16'h0);
    chk("s1.done", done, 1);
    chk("s1.err", err, 0);
    chk("s1.pc", pc, 6);
    chk("s1.busy", busy, 0);

    // branch-if-zero; address upper bits must be ignored
    load(4'd0, 16'hE000, 16'h0000, 16'h0013);
    load(4'd1, 16'h2000, 16'h0000, 16'h0000);
    load(4'd2, 16'h0000, 16'h0000, 16'h0000);
    load(4'd3, 16'hF000, 16'h0000, 16'h0000);
    zo_in = 1'b1;
    pulse_start();
    chk("bz1.done_cleared", done, 0);
    tick();
    chk("bz1.bubble_cmd", cmd_out, 0);
    chk("bz1.pc_taken", pc, 3);
    tick();
    chk("bz1.cmd_halt", cmd_out, 0);
    chk("bz1.done", done, 1);
    chk("bz1.pc", pc, 3);
    chk("bz1.err", err, 0);

    zo_in = 1'b0;
    pulse_start();
    tick();
    chk("bz0.bubble_cmd", cmd_out, 0);
    chk("bz0.pc_fall", pc, 1);
    tick();
    chk("bz0.issue_cmd", cmd_out, 16'h2000);
    chk("bz0.pc", pc, 2);
    tick();
    tick();
    chk("bz0.done", done, 1);
    chk("bz0.pc_halt", pc, 3);

    // run off end of memory; prog_we and start during RUN must be ignored
    for (int i = 0; i < DEPTH; i++) load(AW'(i), 16'h2000, 16'(i), 16'(i));
    pulse_start();
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      if (i == 4) begin
        prog_we = 1'b0; start = 1'b0;
      end
      chk_out($sformatf("ro.issue%0d", i), 16'h2000, 16'(i), 16'(i));
      chk($sformatf("ro.pc%0d", i), pc, (i < DEPTH-1) ? i+1 : DEPTH-1);
      chk($sformatf("ro.busy%0d", i), busy, 1);
      if (i == 3) begin
        prog_we = 1'b1; prog_addr = 4'd5; prog_wdata = {16'hF000, 16'h00AA, 16'h00AA};
        start = 1'b1;
      end
    end
    tick();
    chk_out("ro.end", 16'h0, 16'h0, 16'h0);
    chk("ro.err", err, 1);
    chk("ro.done", done, 1);
    chk("ro.pc", pc, DEPTH-1);
    chk("ro.busy", busy, 0);

    // rerun: entry 5 untouched; async reset mid-run
    pulse_start();
    chk("rr.err_cleared", err, 0);
    chk("rr.done_cleared", done, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_out($sformatf("rr.issue%0d", i), 16'h2000, 16'(i), 16'(i));
    end
    #3 rst = 1'b1;
    #1;
    chk_out("rr.rst", 16'h0, 16'h0, 16'h0);
    chk("rr.rst_pc", pc, 0);
    chk("rr.rst_busy", busy, 0);
    tick();
    rst = 1'b0;

    // async reset while an ALU instruction is held
    load(4'd0, 16'h4000, 16'h0007, 16'h0007);
    pulse_start();
    tick();
    chk_out("hold.issue", 16'h4000, 16'h0007, 16'h0007);
    tick();
    chk_out("hold.held", 16'h4000, 16'h0007, 16'h0007);
    chk("hold.busy", busy, 1);
    #3 rst = 1'b1;
    #1;
    chk_out("hold.rst", 16'h0, 16'h0, 16'h0);
    chk("hold.rst_pc", pc, 0);
    chk("hold.rst_busy", busy, 0);
    chk("hold.rst_done", done, 0);
    chk("hold.rst_err", err, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("hold.idle_busy", busy, 0);
    chk("hold.idle_cmd", cmd_out, 0);

`ifdef SEQ_STEP_EN
    // single-step: each issue waits for a step pulse
    load_s1();
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      tick();
      chk_out($sformatf("st.issue%0d", i), s1_cmd[i], s1_num[i], s1_adr[i]);
      if (s1_cmd[i] == 16'h4000) i++;
      tick();
      chk_out($sformatf("st.pause%0d", i), s1_cmd[i], s1_num[i], s1_adr[i]);
      chk($sformatf("st.busy%0d", i), busy, 1);
      step = 1'b1;
      tick();
      step = 1'b0;
      chk($sformatf("st.resume%0d", i), cmd_out, s1_cmd[i]);
    end
    tick();
    chk("st.done", done, 1);
    chk("st.cmd", cmd_out, 0);
    chk("st.pc", pc, 6);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmd_sequencer.md
Name: cmd_sequencer

Overview:
- Upstream feeder for the CPU TopLevel: holds a small program of {command, number, address} words and streams them onto TopLevel's command/number/address inputs, one per clock.
- Adds HALT and branch-if-zero (consumes TopLevel's ZO flag) so programs run without a testbench hand-driving each step.
- Program is loaded through a write port while the sequencer is idle or halted.

Parameters:
- DATA_W, 16, width of each of command/number/address fields
- DEPTH, 16, program memory entries (power of two, >=2)
- AW, $clog2(DEPTH), program counter width (derived, not overridden)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- prog_we  in  1  program write strobe
- prog_addr  in  AW  program write address
- prog_wdata  in  3*DATA_W  {command, number, address}, command in MSBs
- start  in  1  one-cycle pulse: run from pc=0
- zo_in  in  1  ZO flag from TopLevel
- cmd_out  out  DATA_W  to TopLevel.command
- num_out  out  DATA_W  to TopLevel.number
- addr_out  out  DATA_W  to TopLevel.address
- pc  out  AW  current program counter
- busy  out  1  high in RUN/HOLD
- done  out  1  high in HALT
- err  out  1  ran off end of program without HALT
- step  in  1  only when SEQ_STEP_EN is defined

Behaviour:
- Reset (async, immediate): state=IDLE, pc=0, cmd_out/num_out/addr_out=0, busy=0, done=0, err=0. Program memory is not cleared. Reset mid-run aborts the run at once.
- Program memory: register array, combinational read at pc. Write on clk edge when prog_we=1 and state is IDLE or HALT. prog_we is ignored in RUN/HOLD.
- Opcode = command[15:12].
- IDLE: outputs 0. When start=1: pc<=0, state<=RUN.
- RUN (each edge, decode mem[pc]):
  - op F, HALT: outputs<=0, done<=1, state<=HALT, pc unchanged.
  - op E, branch-if-zero: outputs<=0 (bubble). If zo_in=1, pc<=address[AW-1:0] (upper bits ignored); else pc<=pc+1.
  - op 4, ALU op: outputs<=instruction, pc<=pc+1, state<=HOLD.
  - any other op (including 0 = NOP, 2, 3, 5): outputs<=instruction, pc<=pc+1.
- HOLD: outputs held unchanged for one extra cycle so the ALU result settles. Next state RUN.
- End of memory:
  - If an issued or non-taken instruction sits at pc=DEPTH-1, it is still issued normally (including its HOLD for op 4).
  - Next state is then HALT with err<=1 and done<=1; pc stays at DEPTH-1 with no wrap.
  - A taken branch at DEPTH-1 is legal and does not set err.
- HALT: outputs 0, done=1. start=1 restarts: done<=0, err<=0, pc<=0, state<=RUN.
- start in RUN/HOLD is ignored.
- Latency: start sampled at edge k; first instruction appears on outputs after edge k+1. Each issued instruction is visible for exactly 1 cycle, or 2 cycles for op 4.
- busy and done are registered, derived from next state.

Optional Feature:
- SEQ_STEP_EN defined:
  - step input exists.
  - After every issue (end of the ISSUE cycle, or end of HOLD for op 4), enter PAUSE.
  - PAUSE holds outputs and pc. It returns to RUN on the edge where step=1.
  - busy stays 1 in PAUSE.
  - HALT/err behaviour is unchanged.
- SEQ_STEP_EN undefined: no step port, no PAUSE state, free-running as above.

Decomposition:
- Shared package cmd_seq_pkg holds:
  - opcode constants (OP_NOP=0, OP_STI=2, OP_LD=3, OP_ADD=4, OP_STR=5, OP_BZ=E, OP_HALT=F)
  - state enum (IDLE, RUN, HOLD, HALT, PAUSE)
  - the field-slice offsets of the 48-bit instruction word
- One sub-module, cmd_prog_mem: DEPTH x 3*DATA_W register file, one write port, one combinational read port.

Test Plan:
- Load 2000/0008/0000, 2000/0004/0001, 3000/0/0000, 3001/0/0001, 4000/0/0, 5000/0/0002, F000/0/0, then pulse start → cmd_out shows 2000, 2000, 3000, 3001, 4000, 4000, 5000 on consecutive cycles, with matching num/addr fields. Then outputs 0, done=1, err=0, pc=6.
- Branch: program [0]=E000/0/0003, [1]=2000, [3]=F000. With zo_in=1 → pc jumps to 3, halt, cmd 2000 never issued. With zo_in=0 → 2000 issued at pc=1.
- Run-off: fill all 16 entries with 2000/i/i and no HALT → 16 issues, then err=1, done=1, pc=15.
- Robustness during a run: prog_we during RUN leaves memory unchanged (verify on rerun); start during RUN is ignored; async rst asserted mid-HOLD → all outputs 0 in the same cycle, state IDLE.
- SEQ_STEP_EN: same program as the first scenario → after each issue, outputs hold until a step pulse. 4000 is visible for 2 cycles plus the pause.
